// File: rtl/rgmii_switch_package.sv
// Shared types and Ethernet frame-size constants for the RGMII switch datapath.
package rgmii_switch_package;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FORWARD,
        S_DRAIN
    } state_type;

    localparam int unsigned ETHERNET_MAX_FRAME_BYTES = 1522;
    localparam int unsigned ETHERNET_MIN_FRAME_BYTES = 64;

endpackage

// File: rtl/round_robin_selector.sv
// Combinational round-robin pick: the search starts one past the last grant and wraps,
// so the previous winner has lowest priority.
module round_robin_selector #(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         i_request,
    input  logic [$clog2(NUM_PORTS)-1:0] i_last_index,
    output logic [$clog2(NUM_PORTS)-1:0] o_next_index,
    output logic                         o_found
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [IDX_W-1:0]     w_cand_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_rotated;

    // Rotated slot k holds the port that sits k+1 places after the last grant.
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_rotate
        assign w_cand_idx[k] = IDX_W'((32'(i_last_index) + 32'(k) + 32'd1) % NUM_PORTS);
        assign w_rotated[k]  = i_request[w_cand_idx[k]];
    end

    always_comb begin
        o_found      = |w_rotated;
        o_next_index = i_last_index;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (w_rotated[k]) begin
                o_next_index = w_cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/rgmii_frame_arbiter.sv
// Frame-level round-robin arbiter: one rx port owns the forwarding path from its first byte
// to its last; a byte watchdog truncates runaway frames and drains the remainder.
module rgmii_frame_arbiter
    import rgmii_switch_package::*;
#(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned MAX_FRAME_BYTES = ETHERNET_MAX_FRAME_BYTES,
    parameter int unsigned COUNTER_WIDTH   = 11
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [8*NUM_PORTS-1:0]       port_data,
    input  logic [NUM_PORTS-1:0]         port_first,
    input  logic [NUM_PORTS-1:0]         port_last,
    input  logic [NUM_PORTS-1:0]         port_valid,
    output logic [NUM_PORTS-1:0]         port_ready,
    output logic [7:0]                   out_data,
    output logic                         out_first,
    output logic                         out_last,
    output logic                         out_error,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_PORTS)-1:0] grant_index,
    output logic                         grant_active,
    output logic                         stray_byte_drop
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    state_type r_state, w_state_next;

    logic [IDX_W-1:0]         r_grant, w_next_index;
    logic                     w_found;
    logic [NUM_PORTS-1:0]     w_request, w_stray, w_ready;
    logic                     w_stray_any;
    logic [COUNTER_WIDTH-1:0] r_count, w_count_inc;
    logic                     w_count_hit;
    logic [7:0]               r_out_data, w_sel_data;
    logic                     r_out_last, r_out_error, r_out_valid;
    logic                     w_sel_last, w_sel_valid, w_out_free, w_take;

    assign w_request   = port_valid & port_first;
    assign w_stray     = port_valid & ~port_first;
    assign w_sel_data  = port_data[{r_grant, 3'b000} +: 8];
    assign w_sel_last  = port_last[r_grant];
    assign w_sel_valid = port_valid[r_grant];
    assign w_out_free  = !r_out_valid || out_ready;
    assign w_take      = (r_state == S_FORWARD) && w_sel_valid && w_out_free;
    assign w_count_inc = r_count + COUNTER_WIDTH'(1);
    assign w_count_hit = (w_count_inc == COUNTER_WIDTH'(MAX_FRAME_BYTES));

    round_robin_selector #(
        .NUM_PORTS (NUM_PORTS)
    ) u_selector (
        .i_request    (w_request),
        .i_last_index (r_grant),
        .o_next_index (w_next_index),
        .o_found      (w_found)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_FORWARD;
                end
            end
            S_FORWARD: begin
                if (w_take && w_sel_last) begin
                    w_state_next = S_IDLE;
                end else if (w_take && w_count_hit) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_sel_valid && w_sel_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready      = '0;
        w_stray_any  = 1'b0;
        grant_active = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_found) begin
                    w_ready     = w_stray;
                    w_stray_any = |w_stray;
                end
            end
            S_FORWARD: begin
                w_ready[r_grant] = w_out_free;
                grant_active     = 1'b1;
            end
            S_DRAIN: begin
                w_ready[r_grant] = 1'b1;
                grant_active     = 1'b1;
            end
            default: ;
        endcase
    end

    // Idle-state stray handshakes must not fire while reset is held.
    assign port_ready      = w_ready & {NUM_PORTS{reset_n}};
    assign stray_byte_drop = w_stray_any & reset_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_grant     <= IDX_W'(NUM_PORTS - 1);
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_error <= 1'b0;
            r_out_valid <= 1'b0;
            out_first   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_found) begin
                r_grant <= w_next_index;
                r_count <= '0;
            end
            if (w_take) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                out_first   <= (r_count == '0);
                r_out_last  <= w_sel_last || w_count_hit;
                r_out_error <= !w_sel_last && w_count_hit;
                r_count     <= w_count_inc;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign out_error   = r_out_error;
    assign out_valid   = r_out_valid;
    assign grant_index = r_grant;

endmodule

// File: tb/tb_rgmii_frame_arbiter.sv
// Directed bench: u_dut uses the default watchdog, u_dut_wd a 16-byte watchdog; both see
// the same port stimulus so the watchdog instance can be observed on its own test.
module tb_rgmii_frame_arbiter;

    localparam int unsigned NP = 4;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [8*NP-1:0] port_data = '0;
    logic [NP-1:0]   port_first = '0, port_last = '0, port_valid = '0;
    logic            out_ready = 1'b1;

    logic [NP-1:0] a_port_ready, b_port_ready;
    logic [7:0]    a_out_data, b_out_data;
    logic          a_out_first, a_out_last, a_out_error, a_out_valid;
    logic          b_out_first, b_out_last, b_out_error, b_out_valid;
    logic [1:0]    a_grant_index, b_grant_index;
    logic          a_grant_active, b_grant_active, a_stray, b_stray;

    rgmii_frame_arbiter #(.NUM_PORTS(NP)) u_dut (
        .clock(clock), .reset_n(reset_n), .port_data(port_data), .port_first(port_first),
        .port_last(port_last), .port_valid(port_valid), .port_ready(a_port_ready),
        .out_data(a_out_data), .out_first(a_out_first), .out_last(a_out_last),
        .out_error(a_out_error), .out_valid(a_out_valid), .out_ready(out_ready),
        .grant_index(a_grant_index), .grant_active(a_grant_active),
        .stray_byte_drop(a_stray)
    );

    rgmii_frame_arbiter #(.NUM_PORTS(NP), .MAX_FRAME_BYTES(16), .COUNTER_WIDTH(5)) u_dut_wd (
        .clock(clock), .reset_n(reset_n), .port_data(port_data), .port_first(port_first),
        .port_last(port_last), .port_valid(port_valid), .port_ready(b_port_ready),
        .out_data(b_out_data), .out_first(b_out_first), .out_last(b_out_last),
        .out_error(b_out_error), .out_valid(b_out_valid), .out_ready(out_ready),
        .grant_index(b_grant_index), .grant_active(b_grant_active),
        .stray_byte_drop(b_stray)
    );

    always #5 clock = ~clock;

    int vectors = 0, miscompares = 0, cyc = 0;
    bit use_b = 1'b0;

    int         src_len[NP], src_pos[NP];
    logic [7:0] src_base[NP];
    bit         src_nofirst[NP];

    logic [7:0]    s_data;
    logic          s_valid, s_first, s_last, s_err, s_stray, s_active;
    logic [NP-1:0] s_ready;
    logic [1:0]    s_grant;

    logic [7:0] log_data[$];
    logic [2:0] log_flags[$];
    int         log_cyc[$];

    task automatic present();
        for (int p = 0; p < NP; p++) begin
            port_valid[p]       = src_pos[p] < src_len[p];
            port_data[8*p +: 8] = src_base[p] + 8'(src_pos[p]);
            port_first[p]       = !src_nofirst[p] && (src_pos[p] == 0);
            port_last[p]        = (src_pos[p] == src_len[p] - 1);
        end
    endtask

    task automatic load(input int p, input int len, input logic [7:0] base, input bit nofirst);
        src_len[p] = len; src_pos[p] = 0; src_base[p] = base; src_nofirst[p] = nofirst;
        present();
    endtask

    task automatic clear_log();
        log_data.delete(); log_flags.delete(); log_cyc.delete();
    endtask

    // Sample on the falling edge, then advance sources for bytes handshaked on the rising edge.
    task automatic tick();
        @(negedge clock);
        s_valid  = use_b ? b_out_valid : a_out_valid;
        s_data   = use_b ? b_out_data : a_out_data;
        s_first  = use_b ? b_out_first : a_out_first;
        s_last   = use_b ? b_out_last : a_out_last;
        s_err    = use_b ? b_out_error : a_out_error;
        s_ready  = use_b ? b_port_ready : a_port_ready;
        s_grant  = use_b ? b_grant_index : a_grant_index;
        s_active = use_b ? b_grant_active : a_grant_active;
        s_stray  = a_stray;
        if (s_valid && out_ready) begin
            log_data.push_back(s_data);
            log_flags.push_back({s_first, s_last, s_err});
            log_cyc.push_back(cyc);
        end
        @(posedge clock);
        cyc++;
        #1;
        for (int p = 0; p < NP; p++) if (port_valid[p] && s_ready[p]) src_pos[p]++;
        present();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int p = 0; p < NP; p++) begin
            src_len[p] = 0; src_pos[p] = 0; src_nofirst[p] = 1'b0;
        end
        present();
        out_ready = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        load(1, 1, 8'hEE, 1'b1);
        tick();
        vectors++;
        if ({a_out_valid, a_out_data, a_out_first, a_out_last, a_out_error} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_out: got v=%b d=%h f=%b l=%b e=%b, want all zero", a_out_valid,
                     a_out_data, a_out_first, a_out_last, a_out_error);
        end
        vectors++;
        if (a_port_ready !== 4'b0000) begin
            miscompares++; $display("FAIL reset_port_ready: got %b want 0000", a_port_ready);
        end
        vectors++;
        if (a_grant_index !== 2'd3) begin
            miscompares++; $display("FAIL reset_grant_index: got %0d want 3", a_grant_index);
        end
        vectors++;
        if (a_grant_active !== 1'b0 || a_stray !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: active=%b stray=%b want 0 0", a_grant_active, a_stray);
        end
        do_reset();
        tick();
    endtask

    task automatic test_single_frame();
        int c0, k;
        clear_log();
        load(1, 64, 8'h00, 1'b0);
        c0 = cyc; k = 0;
        while (log_data.size() < 64 && k < 100) begin tick(); k++; end
        vectors++;
        if (log_data.size() != 64) begin
            miscompares++; $display("FAIL single_count: got %0d bytes want 64", log_data.size());
        end
        vectors++;
        if (s_grant !== 2'd1) begin
            miscompares++; $display("FAIL single_grant: got %0d want 1", s_grant);
        end
        for (int i = 0; i < 64 && i < log_data.size(); i++) begin
            vectors++;
            if ({log_data[i], log_flags[i]} !== {8'(i), i == 0, i == 63, 1'b0}
                || log_cyc[i] != c0 + 2 + i) begin
                miscompares++;
                $display("FAIL single_byte[%0d]: got d=%h fle=%b cyc=%0d want d=%h cyc=%0d", i,
                         log_data[i], log_flags[i], log_cyc[i], 8'(i), c0 + 2 + i);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] bases [4];
        logic [7:0] exp_d;
        bit reloaded;
        int c0, k, gap;
        bases = '{8'h10, 8'h20, 8'h30, 8'h40};
        do_reset();
        load(0, 10, 8'h10, 1'b0);
        load(2, 10, 8'h20, 1'b0);
        load(3, 10, 8'h30, 1'b0);
        c0 = cyc; k = 0; reloaded = 1'b0;
        while (log_data.size() < 40 && k < 120) begin
            tick(); k++;
            if (!reloaded && src_pos[0] == 10) begin
                load(0, 10, 8'h40, 1'b0); reloaded = 1'b1;
            end
        end
        vectors++;
        if (log_data.size() != 40) begin
            miscompares++; $display("FAIL rr_count: got %0d bytes want 40", log_data.size());
        end
        vectors++;
        if (log_data.size() > 0 && log_cyc[0] != c0 + 2) begin
            miscompares++; $display("FAIL rr_latency: got cyc %0d want %0d", log_cyc[0], c0 + 2);
        end
        for (int j = 0; j < 40 && j < log_data.size(); j++) begin
            exp_d = bases[j / 10] + 8'(j % 10);
            gap   = (j % 10 == 0) ? 2 : 1;
            vectors++;
            if ({log_data[j], log_flags[j]} !== {exp_d, j % 10 == 0, j % 10 == 9, 1'b0}
                || (j > 0 && log_cyc[j] != log_cyc[j-1] + gap)) begin
                miscompares++;
                $display("FAIL rr_byte[%0d]: got d=%h fle=%b dcyc=%0d want d=%h dcyc=%0d", j,
                         log_data[j], log_flags[j], (j > 0) ? log_cyc[j] - log_cyc[j-1] : 0,
                         exp_d, gap);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        logic       p_stall;
        logic [7:0] p_data;
        int stalls, k;
        pat = 4'b1001; p_stall = 1'b0; p_data = '0; stalls = 0; k = 0;
        clear_log();
        load(1, 8, 8'h50, 1'b0);
        while (log_data.size() < 8 && k < 60) begin
            out_ready = pat[k % 4];
            tick();
            if (p_stall) begin
                vectors++;
                if (s_valid !== 1'b1 || s_data !== p_data) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h", s_valid, s_data,
                             p_data);
                end
            end
            p_stall = s_valid && !out_ready;
            if (p_stall) begin
                stalls++;
                vectors++;
                if (s_ready[1] !== 1'b0) begin
                    miscompares++; $display("FAIL stall_ready: got %b want 0", s_ready[1]);
                end
            end
            p_data = s_data;
            k++;
        end
        out_ready = 1'b1;
        vectors++;
        if (log_data.size() != 8 || stalls == 0) begin
            miscompares++;
            $display("FAIL stall_count: got %0d bytes %0d stalls want 8 bytes >0 stalls",
                     log_data.size(), stalls);
        end
        for (int i = 0; i < 8 && i < log_data.size(); i++) begin
            vectors++;
            if ({log_data[i], log_flags[i]} !== {8'h50 + 8'(i), i == 0, i == 7, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_byte[%0d]: got d=%h fle=%b want d=%h", i, log_data[i],
                         log_flags[i], 8'h50 + 8'(i));
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_watchdog();
        int c0, k;
        use_b = 1'b1;
        clear_log();
        load(0, 20, 8'h60, 1'b0);
        c0 = cyc;
        tick(); tick();
        load(2, 2, 8'h70, 1'b0);
        k = 2;
        while (log_data.size() < 18 && k < 60) begin tick(); k++; end
        vectors++;
        if (log_data.size() != 18 || src_pos[0] != 20) begin
            miscompares++;
            $display("FAIL wd_count: got %0d bytes out, %0d consumed want 18, 20",
                     log_data.size(), src_pos[0]);
        end
        for (int i = 0; i < 16 && i < log_data.size(); i++) begin
            vectors++;
            if ({log_data[i], log_flags[i]} !== {8'h60 + 8'(i), i == 0, i == 15, i == 15}
                || log_cyc[i] != c0 + 2 + i) begin
                miscompares++;
                $display("FAIL wd_byte[%0d]: got d=%h fle=%b cyc=%0d want d=%h cyc=%0d", i,
                         log_data[i], log_flags[i], log_cyc[i], 8'h60 + 8'(i), c0 + 2 + i);
            end
        end
        if (log_data.size() >= 18) begin
            vectors++;
            if ({log_data[16], log_flags[16]} !== {8'h70, 3'b100} || log_cyc[16] != c0 + 23) begin
                miscompares++;
                $display("FAIL wd_next_first: got d=%h fle=%b cyc=%0d want d=70 fle=100 cyc=%0d",
                         log_data[16], log_flags[16], log_cyc[16], c0 + 23);
            end
            vectors++;
            if ({log_data[17], log_flags[17]} !== {8'h71, 3'b010}) begin
                miscompares++;
                $display("FAIL wd_next_last: got d=%h fle=%b want d=71 fle=010", log_data[17],
                         log_flags[17]);
            end
        end
        use_b = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_stray();
        int strays, valids;
        strays = 0; valids = 0;
        load(2, 3, 8'hC0, 1'b1);
        repeat (6) begin
            tick();
            strays += int'(s_stray);
            valids += int'(s_valid);
        end
        vectors++;
        if (strays != 3 || src_pos[2] != 3) begin
            miscompares++;
            $display("FAIL stray_drop: got %0d pulses %0d consumed want 3 3", strays, src_pos[2]);
        end
        vectors++;
        if (valids != 0) begin
            miscompares++; $display("FAIL stray_out_valid: got %0d valid cycles want 0", valids);
        end
    endtask

    task automatic test_mid_reset();
        int k;
        load(3, 10, 8'h80, 1'b0);
        k = 0;
        while (src_pos[3] < 5 && k < 30) begin tick(); k++; end
        vectors++;
        if (src_pos[3] != 5 || a_out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_progress: got pos=%0d v=%b want 5 1", src_pos[3], a_out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({a_out_valid, a_out_data, a_out_first, a_out_last, a_out_error} !== 12'h000) begin
            miscompares++;
            $display("FAIL mid_reset_out: got v=%b d=%h f=%b l=%b e=%b, want all zero",
                     a_out_valid, a_out_data, a_out_first, a_out_last, a_out_error);
        end
        vectors++;
        if (a_port_ready !== 4'b0000 || a_grant_index !== 2'd3 || a_grant_active !== 1'b0
            || a_stray !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ctrl: got rdy=%b g=%0d act=%b stray=%b want 0000 3 0 0",
                     a_port_ready, a_grant_index, a_grant_active, a_stray);
        end
        for (int p = 0; p < NP; p++) begin src_len[p] = 0; src_pos[p] = 0; end
        load(0, 3, 8'h90, 1'b0);
        load(3, 3, 8'hA0, 1'b0);
        repeat (2) tick();
        reset_n = 1'b1;
        clear_log();
        k = 0;
        while (log_data.size() < 6 && k < 30) begin tick(); k++; end
        vectors++;
        if (log_data.size() != 6) begin
            miscompares++; $display("FAIL post_reset_count: got %0d want 6", log_data.size());
        end else begin
            vectors++;
            if ({log_data[0], log_flags[0], log_data[3], log_flags[3]}
                !== {8'h90, 3'b100, 8'hA0, 3'b100}) begin
                miscompares++;
                $display("FAIL post_reset_order: got %h,%h want 90,a0", log_data[0], log_data[3]);
            end
        end
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            src_len[p] = 0; src_pos[p] = 0; src_base[p] = '0; src_nofirst[p] = 1'b0;
        end
        test_reset();
        test_single_frame();
        test_round_robin();
        test_stall();
        test_watchdog();
        test_stray();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
